// File: rtl/sum_arb_if.sv
// ---------------------------------------------------------------------------
// sum_arb_if
// Bundles the requester channels and the result channel of sum_arbiter.
//   req_valid/req_ready/req_data/req_last : per-requester element streams
//   res_valid/res_ready                    : result handshake
//   res_data/res_id/res_count              : sum, owning requester, beat count
//   res_len_err/res_timeout                : job-termination flags
//   busy                                   : arbiter not idle
// Modports:
//   master : requesters + result consumer (drives req_* and res_ready)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface sum_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_LEN    = 8
);
    localparam int RESULT_WIDTH = DATA_WIDTH + $clog2(MAX_LEN);
    localparam int ID_WIDTH     = $clog2(NUM_REQ);
    localparam int CNT_WIDTH    = $clog2(MAX_LEN + 1);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_last;

    logic                    res_valid;
    logic                    res_ready;
    logic [RESULT_WIDTH-1:0] res_data;
    logic [ID_WIDTH-1:0]     res_id;
    logic [CNT_WIDTH-1:0]    res_count;
    logic                    res_len_err;
    logic                    res_timeout;
    logic                    busy;

    modport master (
        output req_valid, req_data, req_last, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_count,
               res_len_err, res_timeout, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, res_ready,
        output req_ready, res_valid, res_data, res_id, res_count,
               res_len_err, res_timeout, busy
    );
endinterface

// File: rtl/sum_arbiter.sv
// ---------------------------------------------------------------------------
// sum_arbiter
// Round-robin arbiter that shares one sequential accumulator among NUM_REQ
// requesters. The granted requester streams up to MAX_LEN unsigned elements;
// the sum is returned tagged with the requester id, the beat count and the
// reason the job ended.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : sum_arb_if.slave (requester streams, result channel, busy)
//
// Optional feature (compile-time macro SUM_ARB_TIMEOUT_EN):
//   defined   -> stall watchdog ends a job after TIMEOUT_CYCLES consecutive
//                cycles in ACCUM without an accepted beat (res_timeout = 1)
//   undefined -> no watchdog, res_timeout is constant 0
// ---------------------------------------------------------------------------
module sum_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 4,
    parameter int MAX_LEN        = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic      clk,
    input  logic      rst,
    sum_arb_if.slave  bus
);
    localparam int RESULT_WIDTH = DATA_WIDTH + $clog2(MAX_LEN);
    localparam int ID_WIDTH     = $clog2(NUM_REQ);
    localparam int CNT_WIDTH    = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t                  state_reg,       state_next;
    logic [ID_WIDTH-1:0]     grant_reg,       grant_next;
    logic [ID_WIDTH-1:0]     last_grant_reg,  last_grant_next;
    logic [RESULT_WIDTH-1:0] acc_reg,         acc_next;
    logic [CNT_WIDTH-1:0]    count_reg,       count_next;
    logic [RESULT_WIDTH-1:0] res_data_reg,    res_data_next;
    logic [ID_WIDTH-1:0]     res_id_reg,      res_id_next;
    logic [CNT_WIDTH-1:0]    res_count_reg,   res_count_next;
    logic                    res_len_err_reg, res_len_err_next;

`ifdef SUM_ARB_TIMEOUT_EN
    localparam int STALL_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_WIDTH-1:0]  stall_reg,       stall_next;
    logic                    res_timeout_reg, res_timeout_next;
`endif

    // Round-robin pick: scan offsets NUM_REQ down to 1 so the lowest offset
    // from last_grant_reg+1 is the one that sticks.
    logic                sel_found;
    logic [ID_WIDTH-1:0] sel_idx;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req_valid[(int'(last_grant_reg) + k) % NUM_REQ]) begin
                sel_found = 1'b1;
                sel_idx   = ID_WIDTH'((int'(last_grant_reg) + k) % NUM_REQ);
            end
        end
    end

    // Ready is a pure decode of registered state: no path from req_valid.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = (state_reg == S_ACCUM) &&
                                       (grant_reg == ID_WIDTH'(gi));
        end
    endgenerate

    logic                    beat;
    logic [RESULT_WIDTH-1:0] beat_sum;
    logic [CNT_WIDTH-1:0]    beat_cnt;

    assign beat     = (state_reg == S_ACCUM) && bus.req_valid[grant_reg];
    assign beat_sum = acc_reg + RESULT_WIDTH'(bus.req_data[grant_reg]);
    assign beat_cnt = count_reg + 1'b1;

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        last_grant_next  = last_grant_reg;
        acc_next         = acc_reg;
        count_next       = count_reg;
        res_data_next    = res_data_reg;
        res_id_next      = res_id_reg;
        res_count_next   = res_count_reg;
        res_len_err_next = res_len_err_reg;
`ifdef SUM_ARB_TIMEOUT_EN
        stall_next       = stall_reg;
        res_timeout_next = res_timeout_reg;
`endif

        unique case (state_reg)
            S_IDLE: begin
                if (sel_found) begin
                    grant_next = sel_idx;
                    acc_next   = '0;
                    count_next = '0;
`ifdef SUM_ARB_TIMEOUT_EN
                    stall_next = '0;
`endif
                    state_next = S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (beat) begin
                    acc_next   = beat_sum;
                    count_next = beat_cnt;
`ifdef SUM_ARB_TIMEOUT_EN
                    stall_next = '0;
`endif
                    // A full-length list without last still closes the job;
                    // the requester's next beat starts a fresh one.
                    if (bus.req_last[grant_reg] ||
                        (count_reg == CNT_WIDTH'(MAX_LEN - 1))) begin
                        res_data_next    = beat_sum;
                        res_id_next      = grant_reg;
                        res_count_next   = beat_cnt;
                        res_len_err_next = ~bus.req_last[grant_reg];
`ifdef SUM_ARB_TIMEOUT_EN
                        res_timeout_next = 1'b0;
`endif
                        last_grant_next  = grant_reg;
                        state_next       = S_RESULT;
                    end
                end
`ifdef SUM_ARB_TIMEOUT_EN
                else if (stall_reg == STALL_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    // Watchdog expiry reports whatever was gathered so far.
                    res_data_next    = acc_reg;
                    res_id_next      = grant_reg;
                    res_count_next   = count_reg;
                    res_len_err_next = 1'b0;
                    res_timeout_next = 1'b1;
                    last_grant_next  = grant_reg;
                    state_next       = S_RESULT;
                end else begin
                    stall_next = stall_reg + 1'b1;
                end
`endif
            end

            S_RESULT: begin
                if (bus.res_ready) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            grant_reg       <= '0;
            last_grant_reg  <= ID_WIDTH'(NUM_REQ - 1);
            acc_reg         <= '0;
            count_reg       <= '0;
            res_data_reg    <= '0;
            res_id_reg      <= '0;
            res_count_reg   <= '0;
            res_len_err_reg <= 1'b0;
`ifdef SUM_ARB_TIMEOUT_EN
            stall_reg       <= '0;
            res_timeout_reg <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            last_grant_reg  <= last_grant_next;
            acc_reg         <= acc_next;
            count_reg       <= count_next;
            res_data_reg    <= res_data_next;
            res_id_reg      <= res_id_next;
            res_count_reg   <= res_count_next;
            res_len_err_reg <= res_len_err_next;
`ifdef SUM_ARB_TIMEOUT_EN
            stall_reg       <= stall_next;
            res_timeout_reg <= res_timeout_next;
`endif
        end
    end

    assign bus.res_valid   = (state_reg == S_RESULT);
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.res_data    = res_data_reg;
    assign bus.res_id      = res_id_reg;
    assign bus.res_count   = res_count_reg;
    assign bus.res_len_err = res_len_err_reg;
`ifdef SUM_ARB_TIMEOUT_EN
    assign bus.res_timeout = res_timeout_reg;
`else
    assign bus.res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sum_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sum_arbiter
// Directed bench for sum_arbiter. Expected results are queued as each job is
// driven; a negedge monitor pops and compares every result handshake.
// ---------------------------------------------------------------------------
module tb_sum_arbiter;
    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int ML  = 8;
    localparam int RW  = DW + $clog2(ML);
    localparam int IW  = $clog2(NR);
    localparam int CW  = $clog2(ML + 1);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sum_arb_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_LEN(ML)) bus ();

    sum_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_LEN(ML), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [RW-1:0] data;
        logic [CW-1:0] count;
        logic          len_err;
        logic          timeout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   failures  = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [RW-1:0] data,
                            input int count, input logic le, input logic to);
        exp_t e;
        e.id      = IW'(id);
        e.data    = data;
        e.count   = CW'(count);
        e.len_err = le;
        e.timeout = to;
        exp_q.push_back(e);
    endtask

    // Drive one element and return one tick after the edge that took it.
    task automatic send_beat(input int id, input logic [DW-1:0] d, input logic l);
        int n = 0;
        bus.req_valid[id] = 1'b1;
        bus.req_data[id]  = d;
        bus.req_last[id]  = l;
        @(negedge clk);
        while (!bus.req_ready[id] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("beat_ready_wait", 64'(n < 200), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
        bus.req_last[id]  = 1'b0;
    endtask

    // Wait (bounded) for res_valid; n counts negedges waited.
    task automatic wait_res(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 100);
        check("res_valid_wait", 64'(bus.res_valid), 64'd1);
    endtask

    // Scoreboard monitor: one line per result transaction.
    always @(negedge clk) begin
        if (rst && bus.res_valid && bus.res_ready) begin
            $display("[TB] result id=%0d data=%0h count=%0d len_err=%0b timeout=%0b",
                     bus.res_id, bus.res_data, bus.res_count,
                     bus.res_len_err, bus.res_timeout);
            check("result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("res_id",      64'(bus.res_id),      64'(mon_e.id));
                check("res_data",    64'(bus.res_data),    64'(mon_e.data));
                check("res_count",   64'(bus.res_count),   64'(mon_e.count));
                check("res_len_err", 64'(bus.res_len_err), 64'(mon_e.len_err));
                check("res_timeout", 64'(bus.res_timeout), 64'(mon_e.timeout));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.res_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_res_data",  64'(bus.res_data),  64'd0);
        check("rst_res_count", 64'(bus.res_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Test 1: requester 0 sends 3,5,7
        $display("[TB] test1: requester 0 list 3,5,7");
        push_exp(0, RW'(15), 3, 1'b0, 1'b0);
        bus.req_data[0]  = 32'd3;
        bus.req_last[0]  = 1'b0;
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        check("t1_ready_in_idle", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("t1_grant_ready", 64'(bus.req_ready), 64'b0001);
        check("t1_busy",        64'(bus.busy),      64'd1);
        @(posedge clk);
        #1;
        bus.req_data[0] = 32'd5;
        @(posedge clk);
        #1;
        bus.req_data[0] = 32'd7;
        bus.req_last[0] = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        bus.req_last[0]  = 1'b0;
        @(negedge clk);
        check("t1_res_valid_rise", 64'(bus.res_valid), 64'd1);
        @(negedge clk);
        check("t1_res_valid_fall", 64'(bus.res_valid), 64'd0);

        // Test 2: all four requesters continuously valid, one element each
        $display("[TB] test2: round-robin over 4 requesters");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++)
                push_exp(i, RW'(i + 1), 1, 1'b0, 1'b0);
        for (int i = 0; i < NR; i++) begin
            bus.req_data[i]  = DW'(i + 1);
            bus.req_last[i]  = 1'b1;
            bus.req_valid[i] = 1'b1;
        end
        for (int j = 0; j < 2 * NR; j++) begin
            wait_res(n);
            if (j == 2 * NR - 1) begin
                bus.req_valid = '0;
                bus.req_last  = '0;
            end
        end
        repeat (3) @(negedge clk);
        check("t2_idle_after", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;

        // Test 3: MAX_LEN beats of all-ones without last
        $display("[TB] test3: requester 2 full-length list, no last");
        push_exp(2, 35'h7_FFFF_FFF8, ML, 1'b1, 1'b0);
        for (int i = 0; i < ML; i++)
            send_beat(2, 32'hFFFF_FFFF, 1'b0);
        wait_res(n);
        @(posedge clk);
        #1;

        // Test 4: backpressure on the result channel
        $display("[TB] test4: res_ready held low in RESULT");
        bus.res_ready = 1'b0;
        push_exp(1, RW'(30), 2, 1'b0, 1'b0);
        send_beat(1, 32'd10, 1'b0);
        send_beat(1, 32'd20, 1'b1);
        push_exp(0, RW'(5), 1, 1'b0, 1'b0);
        bus.req_data[0]  = 32'd5;
        bus.req_last[0]  = 1'b1;
        bus.req_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_hold_valid", 64'(bus.res_valid), 64'd1);
            check("t4_hold_data",  64'(bus.res_data),  64'd30);
            check("t4_hold_id",    64'(bus.res_id),    64'd1);
            check("t4_hold_count", 64'(bus.res_count), 64'd2);
            check("t4_no_ready",   64'(bus.req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_idle_ready", 64'(bus.req_ready), 64'd0);
        check("t4_idle_valid", 64'(bus.res_valid), 64'd0);
        @(negedge clk);
        check("t4_next_grant", 64'(bus.req_ready), 64'b0001);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        bus.req_last[0]  = 1'b0;
        wait_res(n);
        @(posedge clk);
        #1;

        // Test 5: reset mid-ACCUM after two beats
        $display("[TB] test5: reset during ACCUM");
        send_beat(3, 32'd100, 1'b0);
        send_beat(3, 32'd200, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_exp(0, RW'(11), 1, 1'b0, 1'b0);
        push_exp(1, RW'(7), 1, 1'b0, 1'b0);
        bus.req_data[0]  = 32'd11;
        bus.req_last[0]  = 1'b1;
        bus.req_valid[0] = 1'b1;
        bus.req_data[1]  = 32'd7;
        bus.req_last[1]  = 1'b1;
        bus.req_valid[1] = 1'b1;
        @(negedge clk);
        check("t5_res_valid", 64'(bus.res_valid),   64'd0);
        check("t5_req_ready", 64'(bus.req_ready),   64'd0);
        check("t5_busy",      64'(bus.busy),        64'd0);
        check("t5_res_data",  64'(bus.res_data),    64'd0);
        check("t5_res_count", 64'(bus.res_count),   64'd0);
        check("t5_res_id",    64'(bus.res_id),      64'd0);
        check("t5_len_err",   64'(bus.res_len_err), 64'd0);
        @(negedge clk);
        check("t5_grant_req0", 64'(bus.req_ready), 64'b0001);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        bus.req_last[0]  = 1'b0;
        send_beat(1, 32'd7, 1'b1);
        wait_res(n);
        @(posedge clk);
        #1;

`ifdef SUM_ARB_TIMEOUT_EN
        // Test 6: one beat then a stall until the watchdog fires
        $display("[TB] test6: stall watchdog");
        push_exp(1, RW'(9), 1, 1'b0, 1'b1);
        send_beat(1, 32'd9, 1'b0);
        wait_res(n);
        check("t6_timeout_latency", 64'(n), 64'd17);
        @(posedge clk);
        #1;
`endif

        repeat (4) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_busy",        64'(bus.busy),      64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
